cpu_pc_unit: RTL and testbench
==============================

# cpu_pc_unit

Program-counter and next-PC stage of the single-cycle MIPS core, sitting directly upstream of the control decoder. It holds the PC and supervisor bit, and picks the next PC from the decoder's PCSrc selection plus the branch and jump operands. It also arbitrates interrupt requests and illegal-opcode traps and drives the decoder's Interrupt/Exception inputs. It provides the link address written by jal/jalr/trap entry.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, PC after reset (kernel mode)
- ILLOP_PC, 32'h8000_0004, interrupt vector
- XADR_PC, 32'h8000_0008, exception vector

Ports:
- clk  input  1  core clock
- reset  input  1  asynchronous, active-low reset
- PCSrc  input  2  from decoder: 00 PC+4, 01 branch, 10 j/jal, 11 jr/jalr
- BranchCond  input  1  ALU result bit 0 (1 = branch condition true)
- Instr  input  26  current instruction bits [25:0]
- RegA  input  32  rs read data (jr/jalr target)
- IllegalOp  input  1  undecodable opcode in current instruction
- IRQ  input  1  interrupt request from timer/peripherals
- Stall  input  1  hold PC (instruction memory not ready)
- PC  output  32  current PC, registered
- PCPlus4  output  32  PC+4 (jal/jalr link)
- LinkAddr  output  32  value for $26 on trap entry
- Interrupt  output  1  interrupt accepted this cycle (to decoder)
- Exception  output  1  exception accepted this cycle (to decoder)

## Operation
- PC[31] is the supervisor bit: 1 = kernel, 0 = user.
- PCPlus4 = {PC[31], PC[30:0]+4}. The add wraps within bits 30:0, so the mode bit is never carried into.
- Branch target = PCPlus4 + ({{14{Instr[15]}},Instr[15:0],2'b00}). Bit 31 is forced to PC[31].
- Jump target = {PC[31], PCPlus4[30:28], Instr[25:0], 2'b00}.
- jr target = {PC[31] & RegA[31], RegA[30:0]}. User code cannot enter kernel mode by jr. Kernel code returns to user by jr with RegA[31]=0.
- Pending interrupt (pend) is defined under Configuration.
- Interrupt = pend & ~PC[31] & ~Stall.
- Exception = IllegalOp & ~PC[31] & ~Stall & ~Interrupt. An interrupt wins; the illegal instruction is not executed and traps again on return.
- Next PC, in priority order:
  - Stall: PC holds.
  - Interrupt: ILLOP_PC.
  - Exception: XADR_PC.
  - PCSrc=01 with BranchCond=1: branch target.
  - PCSrc=01 with BranchCond=0: PCPlus4.
  - PCSrc=10: jump target.
  - PCSrc=11: jr target.
  - PCSrc=00: PCPlus4.
- LinkAddr:
  - Interrupt: PC (interrupted instruction is re-executed).
  - Otherwise: PCPlus4 (exception resumes after the faulting instruction).
- IllegalOp in kernel mode is not trapped; the instruction proceeds as a no-op with PC+4.

## Timing
- PC is updated on the rising clk edge; all other outputs are combinational from PC, the pend register and the inputs.
- reset low, any time and asynchronously: PC=RESET_PC, pend=0. Consequently Interrupt=0 and Exception=0 (kernel mode).
- Latency: the selected target appears on PC one edge after selection. There is no delay slot.
- Stall:
  - Freezes PC.
  - Masks Interrupt/Exception.
  - Does not clear pend; a latched request is accepted in the first unstalled user-mode cycle.
- pend clears on the same edge that accepts the interrupt (Interrupt=1). It is not cleared if Stall or kernel mode blocks acceptance.
- Simultaneous new IRQ edge and acceptance: pend stays 1. The second request is taken after kernel returns to user.
- PC wrap: PC=32'h7FFF_FFFC with PCSrc=00 gives 32'h0000_0000; mode stays user.

## Configuration
- IRQ_LATCH_EN defined:
  - pend is a register, set on a rising edge of IRQ (registered IRQ_d = 0 and IRQ = 1) and cleared on acceptance.
  - IRQ_d resets to 0.
  - A one-cycle IRQ pulse is never lost.
- IRQ_LATCH_EN undefined:
  - pend = IRQ (level-sensitive) and no registers are added.
  - The source must hold IRQ until serviced.

## Test plan
- Release reset, PCSrc=00, no stalls, 3 cycles -> PC reads 8000_0000, 8000_0004, 8000_0008, 8000_000C. Interrupt=0 throughout.
- Kernel jr: PC=8000_0010, PCSrc=11, RegA=0000_0100 -> PC=0000_0100. Then beq with BranchCond=1, Instr[15:0]=FFFE -> PC=0000_00FC.
- User jr: PC=0000_0200, PCSrc=11, RegA=8000_0040 -> PC=0000_0040 (mode escalation blocked). Then j with Instr[25:0]=000_0040 -> PC=0000_0100.
- Interrupt vs illegal op:
  - Setup: user PC=0000_0300, one-cycle IRQ pulse with IllegalOp=1, IRQ_LATCH_EN defined.
  - Response: Interrupt=1, Exception=0, LinkAddr=0000_0300, next PC=8000_0004, pend=0 afterwards.
  - Same pulse with the macro undefined: a pulse arriving while in kernel mode is lost.
- Exception alone: user PC=0000_0400, IllegalOp=1 -> Exception=1, LinkAddr=0000_0404, next PC=8000_0008.
- Stall and reset:
  - Stall=1 for 2 cycles while pend=1 in user mode: PC holds and Interrupt=0.
  - Stall drops: Interrupt=1 that cycle.
  - reset asserted mid-cycle: PC goes to 8000_0000 immediately, pend=0.

Source files
------------

// File: rtl/cpu_pc_unit.sv
// rtl/cpu_pc_unit.sv - PC register, next-PC selection and interrupt/exception arbitration
// Define IRQ_LATCH_EN to latch IRQ rising edges into a pending register; otherwise IRQ is level-sensitive.
module cpu_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] ILLOP_PC = 32'h8000_0004,
  parameter logic [31:0] XADR_PC  = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  PCSrc,
  input  logic        BranchCond,
  input  logic [25:0] Instr,
  input  logic [31:0] RegA,
  input  logic        IllegalOp,
  input  logic        IRQ,
  input  logic        Stall,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic [31:0] LinkAddr,
  output logic        Interrupt,
  output logic        Exception
);

  logic [31:0] r_pc;
  logic [31:0] w_pc_plus4;
  logic [30:0] w_br_off;
  logic [30:0] w_br_sum;
  logic [31:0] w_br_target;
  logic [31:0] w_jmp_target;
  logic [31:0] w_jr_target;
  logic [31:0] w_next_pc;
  logic        w_pend;
  logic        w_interrupt;
  logic        w_exception;

  // Address arithmetic stays within bits 30:0 so the supervisor bit is never carried into.
  assign w_pc_plus4   = {r_pc[31], r_pc[30:0] + 31'd4};
  assign w_br_off     = {{13{Instr[15]}}, Instr[15:0], 2'b00};
  assign w_br_sum     = w_pc_plus4[30:0] + w_br_off;
  assign w_br_target  = {r_pc[31], w_br_sum};
  assign w_jmp_target = {r_pc[31], w_pc_plus4[30:28], Instr, 2'b00};
  // User code cannot raise its own privilege through a register jump.
  assign w_jr_target  = {r_pc[31] & RegA[31], RegA[30:0]};

`ifdef IRQ_LATCH_EN
  logic r_irq_d;
  logic r_pend;

  // A new rising edge wins over acceptance so a back-to-back request is kept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_irq_d <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      r_irq_d <= IRQ;
      r_pend  <= (IRQ & ~r_irq_d) | (r_pend & ~w_interrupt);
    end
  end

  assign w_pend = r_pend;
`else
  assign w_pend = IRQ;
`endif

  assign w_interrupt = w_pend & ~r_pc[31] & ~Stall;
  assign w_exception = IllegalOp & ~r_pc[31] & ~Stall & ~w_interrupt;

  always_comb begin
    w_next_pc = w_pc_plus4;
    if (Stall) begin
      w_next_pc = r_pc;
    end else if (w_interrupt) begin
      w_next_pc = ILLOP_PC;
    end else if (w_exception) begin
      w_next_pc = XADR_PC;
    end else begin
      case (PCSrc)
        2'b01:   w_next_pc = BranchCond ? w_br_target : w_pc_plus4;
        2'b10:   w_next_pc = w_jmp_target;
        2'b11:   w_next_pc = w_jr_target;
        default: w_next_pc = w_pc_plus4;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  // An interrupted instruction is re-executed; a faulting one resumes after itself.
  assign LinkAddr  = w_interrupt ? r_pc : w_pc_plus4;
  assign PC        = r_pc;
  assign PCPlus4   = w_pc_plus4;
  assign Interrupt = w_interrupt;
  assign Exception = w_exception;

endmodule

// File: tb/tb_cpu_pc_unit.sv
// tb/tb_cpu_pc_unit.sv - directed and randomized checks of cpu_pc_unit against a reference model
module tb_cpu_pc_unit;

`ifdef IRQ_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  PCSrc = 2'b00;
  logic        BranchCond = 1'b0;
  logic [25:0] Instr = 26'h0;
  logic [31:0] RegA = 32'h0;
  logic        IllegalOp = 1'b0;
  logic        IRQ = 1'b0;
  logic        Stall = 1'b0;
  logic [31:0] PC, PCPlus4, LinkAddr;
  logic        Interrupt, Exception;

  int n_cmp = 0;
  int n_fail = 0;

  cpu_pc_unit dut (
    .clk(clk), .reset(reset), .PCSrc(PCSrc), .BranchCond(BranchCond), .Instr(Instr),
    .RegA(RegA), .IllegalOp(IllegalOp), .IRQ(IRQ), .Stall(Stall), .PC(PC),
    .PCPlus4(PCPlus4), .LinkAddr(LinkAddr), .Interrupt(Interrupt), .Exception(Exception)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_in(input logic [1:0] src, input logic bc, input logic [25:0] ins,
                        input logic [31:0] ra, input logic ill, input logic irq, input logic stl);
    PCSrc = src; BranchCond = bc; Instr = ins; RegA = ra; IllegalOp = ill; IRQ = irq; Stall = stl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(2'b00, 1'b0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    set_in(2'b00, 1'b0, 26'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    tick();
    tick();
    n_cmp++; if (PC !== 32'h8000_0000) begin n_fail++; $display("FAIL reset_pc: got %h want %h", PC, 32'h8000_0000); end
    n_cmp++; if (Interrupt !== 1'b0) begin n_fail++; $display("FAIL reset_int: got %b want 0", Interrupt); end
    n_cmp++; if (Exception !== 1'b0) begin n_fail++; $display("FAIL reset_exc: got %b want 0", Exception); end
    set_in(2'b00, 1'b0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (PC !== 32'h8000_0000 + 32'(4 * i)) begin n_fail++; $display("FAIL seq_pc%0d: got %h want %h", i, PC, 32'h8000_0000 + 32'(4 * i)); end
      n_cmp++; if (Interrupt !== 1'b0) begin n_fail++; $display("FAIL seq_int%0d: got %b want 0", i, Interrupt); end
      tick();
    end
  endtask

  task automatic test_kernel_jr_branch();
    n_cmp++; if (PC !== 32'h8000_0010) begin n_fail++; $display("FAIL kjr_start: got %h want %h", PC, 32'h8000_0010); end
    set_in(2'b11, 1'b0, 26'h0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    tick();
    n_cmp++; if (PC !== 32'h0000_0100) begin n_fail++; $display("FAIL kjr_pc: got %h want %h", PC, 32'h0000_0100); end
    set_in(2'b01, 1'b1, 26'h000FFFE, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    n_cmp++; if (PC !== 32'h0000_00FC) begin n_fail++; $display("FAIL beq_back: got %h want %h", PC, 32'h0000_00FC); end
  endtask

  task automatic test_user_jr_jump();
    do_reset();
    set_in(2'b11, 1'b0, 26'h0, 32'h0000_0200, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(2'b11, 1'b0, 26'h0, 32'h8000_0040, 1'b0, 1'b0, 1'b0);
    tick();
    n_cmp++; if (PC !== 32'h0000_0040) begin n_fail++; $display("FAIL ujr_blocked: got %h want %h", PC, 32'h0000_0040); end
    set_in(2'b10, 1'b0, 26'h000_0040, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    n_cmp++; if (PC !== 32'h0000_0100) begin n_fail++; $display("FAIL jump: got %h want %h", PC, 32'h0000_0100); end
  endtask

  task automatic test_irq_vs_illop();
    do_reset();
    set_in(2'b11, 1'b0, 26'h0, 32'h0000_0300, 1'b0, 1'b1, 1'b0);
    tick();
    set_in(2'b00, 1'b0, 26'h0, 32'h0, 1'b1, !LATCH, 1'b0);
    #1;
    n_cmp++; if (Interrupt !== 1'b1) begin n_fail++; $display("FAIL irq_int: got %b want 1", Interrupt); end
    n_cmp++; if (Exception !== 1'b0) begin n_fail++; $display("FAIL irq_exc: got %b want 0", Exception); end
    n_cmp++; if (LinkAddr !== 32'h0000_0300) begin n_fail++; $display("FAIL irq_link: got %h want %h", LinkAddr, 32'h0000_0300); end
    tick();
    n_cmp++; if (PC !== 32'h8000_0004) begin n_fail++; $display("FAIL irq_vec: got %h want %h", PC, 32'h8000_0004); end
    set_in(2'b11, 1'b0, 26'h0, 32'h0000_0500, 1'b0, 1'b0, 1'b0);
    tick();
    #1;
    n_cmp++; if (Interrupt !== 1'b0) begin n_fail++; $display("FAIL irq_pend_cleared: got %b want 0", Interrupt); end
  endtask

  task automatic test_kernel_pulse();
    do_reset();
    set_in(2'b00, 1'b0, 26'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    set_in(2'b11, 1'b0, 26'h0, 32'h0000_0600, 1'b0, 1'b0, 1'b0);
    tick();
    #1;
    n_cmp++; if (Interrupt !== LATCH) begin n_fail++; $display("FAIL kpulse_int: got %b want %b", Interrupt, LATCH); end
  endtask

  task automatic test_exception();
    do_reset();
    set_in(2'b11, 1'b0, 26'h0, 32'h0000_0400, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(2'b00, 1'b0, 26'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    #1;
    n_cmp++; if (Exception !== 1'b1) begin n_fail++; $display("FAIL exc_flag: got %b want 1", Exception); end
    n_cmp++; if (Interrupt !== 1'b0) begin n_fail++; $display("FAIL exc_int: got %b want 0", Interrupt); end
    n_cmp++; if (LinkAddr !== 32'h0000_0404) begin n_fail++; $display("FAIL exc_link: got %h want %h", LinkAddr, 32'h0000_0404); end
    tick();
    n_cmp++; if (PC !== 32'h8000_0008) begin n_fail++; $display("FAIL exc_vec: got %h want %h", PC, 32'h8000_0008); end
    #1;
    n_cmp++; if (Exception !== 1'b0) begin n_fail++; $display("FAIL exc_kernel: got %b want 0", Exception); end
    tick();
    n_cmp++; if (PC !== 32'h8000_000C) begin n_fail++; $display("FAIL exc_kernel_pc: got %h want %h", PC, 32'h8000_000C); end
  endtask

  task automatic test_stall();
    do_reset();
    set_in(2'b11, 1'b0, 26'h0, 32'h0000_0700, 1'b0, 1'b1, 1'b0);
    tick();
    set_in(2'b00, 1'b0, 26'h0, 32'h0, 1'b0, !LATCH, 1'b1);
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if (Interrupt !== 1'b0) begin n_fail++; $display("FAIL stall_int%0d: got %b want 0", i, Interrupt); end
      tick();
      n_cmp++; if (PC !== 32'h0000_0700) begin n_fail++; $display("FAIL stall_pc%0d: got %h want %h", i, PC, 32'h0000_0700); end
    end
    Stall = 1'b0;
    #1;
    n_cmp++; if (Interrupt !== 1'b1) begin n_fail++; $display("FAIL unstall_int: got %b want 1", Interrupt); end
    n_cmp++; if (LinkAddr !== 32'h0000_0700) begin n_fail++; $display("FAIL unstall_link: got %h want %h", LinkAddr, 32'h0000_0700); end
    tick();
    n_cmp++; if (PC !== 32'h8000_0004) begin n_fail++; $display("FAIL unstall_vec: got %h want %h", PC, 32'h8000_0004); end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_in(2'b11, 1'b0, 26'h0, 32'h0000_0800, 1'b0, 1'b1, 1'b0);
    tick();
    set_in(2'b00, 1'b0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    n_cmp++; if (Interrupt !== LATCH) begin n_fail++; $display("FAIL prereset_int: got %b want %b", Interrupt, LATCH); end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (PC !== 32'h8000_0000) begin n_fail++; $display("FAIL async_reset_pc: got %h want %h", PC, 32'h8000_0000); end
    #1;
    reset = 1'b1;
    set_in(2'b11, 1'b0, 26'h0, 32'h0000_0900, 1'b0, 1'b0, 1'b0);
    tick();
    #1;
    n_cmp++; if (PC !== 32'h0000_0900) begin n_fail++; $display("FAIL postreset_pc: got %h want %h", PC, 32'h0000_0900); end
    n_cmp++; if (Interrupt !== 1'b0) begin n_fail++; $display("FAIL postreset_pend: got %b want 0", Interrupt); end
  endtask

  task automatic test_wrap();
    do_reset();
    set_in(2'b11, 1'b0, 26'h0, 32'h7FFF_FFFC, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(2'b00, 1'b0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    n_cmp++; if (PCPlus4 !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_plus4: got %h want %h", PCPlus4, 32'h0000_0000); end
    tick();
    n_cmp++; if (PC !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_user: got %h want %h", PC, 32'h0000_0000); end
    do_reset();
    set_in(2'b11, 1'b0, 26'h0, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(2'b00, 1'b0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    n_cmp++; if (PC !== 32'h8000_0000) begin n_fail++; $display("FAIL wrap_kernel: got %h want %h", PC, 32'h8000_0000); end
  endtask

  task automatic test_random();
    logic [31:0] m_pc, e_p4, e_link, e_next, off, kbit;
    logic        m_pend, m_irq_d, pend, e_int, e_exc;
    do_reset();
    m_pc = 32'h8000_0000; m_pend = 1'b0; m_irq_d = 1'b0;
    for (int c = 0; c < 600; c++) begin
      set_in(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 26'($urandom), $urandom,
             $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
      kbit   = m_pc & 32'h8000_0000;
      e_p4   = kbit | ((m_pc + 32'd4) & 32'h7FFF_FFFF);
      pend   = LATCH ? m_pend : IRQ;
      e_int  = pend && kbit == 0 && !Stall;
      e_exc  = IllegalOp && kbit == 0 && !Stall && !e_int;
      e_link = e_int ? m_pc : e_p4;
      off    = {{16{Instr[15]}}, Instr[15:0]} << 2;
      if (Stall) e_next = m_pc;
      else if (e_int) e_next = 32'h8000_0004;
      else if (e_exc) e_next = 32'h8000_0008;
      else if (PCSrc == 2'd1) e_next = BranchCond ? (kbit | ((e_p4 + off) & 32'h7FFF_FFFF)) : e_p4;
      else if (PCSrc == 2'd2) e_next = kbit | (e_p4 & 32'h7000_0000) | {4'h0, Instr, 2'b00};
      else if (PCSrc == 2'd3) e_next = (RegA & 32'h7FFF_FFFF) | (kbit & RegA);
      else e_next = e_p4;
      #1;
      n_cmp++;
      if (PCPlus4 !== e_p4 || LinkAddr !== e_link || Interrupt !== e_int || Exception !== e_exc) begin
        n_fail++;
        $display("FAIL rand_comb cyc %0d: got p4=%h link=%h int=%b exc=%b want p4=%h link=%h int=%b exc=%b",
                 c, PCPlus4, LinkAddr, Interrupt, Exception, e_p4, e_link, e_int, e_exc);
      end
      if (IRQ && !m_irq_d) m_pend = 1'b1;
      else if (e_int) m_pend = 1'b0;
      m_irq_d = IRQ;
      m_pc = e_next;
      tick();
      n_cmp++; if (PC !== m_pc) begin n_fail++; $display("FAIL rand_pc cyc %0d: got %h want %h", c, PC, m_pc); end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_kernel_jr_branch();
    test_user_jr_jump();
    test_irq_vs_illop();
    test_kernel_pulse();
    test_exception();
    test_stall();
    test_async_reset();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
